// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access-size encodings and the response-queue entry layout
// used by the SRAM-like data responder.
package cpu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Width of the per-entry latency counter; the responder's DLY_W must match.
  localparam int unsigned RESP_CNT_W = 4;

  typedef struct packed {
    logic                  is_read;
    logic [31:0]           data;
    logic [RESP_CNT_W-1:0] cnt;
  } resp_entry_t;

endpackage

// File: rtl/resp_queue.sv
// Circular response buffer. Every stored entry counts its own latency down to zero
// regardless of position; only the head may leave, and only once its counter is zero.
module resp_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  resp_entry_t              push_entry,
  input  logic                     pop,
  output resp_entry_t              head,
  output logic                     head_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  resp_entry_t      r_q [DEPTH];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= next_ptr(r_tail);
      if (pop)  r_head <= next_ptr(r_head);
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A freshly pushed entry starts at its full delay; all others tick down in parallel.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && (r_tail == PTR_W'(i))) begin
        r_q[i] <= push_entry;
      end else if (r_q[i].cnt != '0) begin
        r_q[i].cnt <= r_q[i].cnt - 1'b1;
      end
    end
  end

  assign head       = r_q[r_head];
  assign head_ready = (r_count != '0) && (head.cnt == '0);
  assign count      = r_count;

endmodule

// File: rtl/sram_like_data_responder.sv
// Data-side SRAM-like responder: word-addressed memory with byte-strobe writes,
// bounded outstanding requests and per-request configurable response latency.
module sram_like_data_responder
  import cpu_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned DLY_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             wr,
  input  logic [1:0]       size,
  input  logic [31:0]      addr,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  output logic             addr_ok,
  output logic             data_ok,
  output logic [31:0]      rdata,
  input  logic [DLY_W-1:0] cfg_delay,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

  logic [31:0]      r_mem [2**AW];
  logic             r_reset_q;
  logic [AW-1:0]    w_idx;
  logic             w_accept;
  logic [CNT_W-1:0] w_count;
  resp_entry_t      w_push_entry;
  resp_entry_t      w_head;
  logic             w_head_ready;
  logic             w_unused;

  assign w_idx    = addr[AW+1:2];
  assign w_unused = ^{size, addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    r_reset_q <= reset;
  end

  // Held low for the reset cycle and the one after it, so no request lands mid-reset.
  assign addr_ok  = !reset && !r_reset_q && (w_count < CNT_W'(OUTSTANDING));
  assign w_accept = req && addr_ok;

  always_ff @(posedge clk) begin
    if (w_accept && wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_push_entry         = '0;
    w_push_entry.is_read = !wr;
    w_push_entry.data    = wr ? '0 : r_mem[w_idx];
    w_push_entry.cnt     = RESP_CNT_W'(cfg_delay);
  end

  resp_queue #(
    .DEPTH (OUTSTANDING)
  ) u_resp_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (w_accept),
    .push_entry (w_push_entry),
    .pop        (data_ok),
    .head       (w_head),
    .head_ready (w_head_ready),
    .count      (w_count)
  );

  assign data_ok = w_head_ready && !reset;
  assign rdata   = (data_ok && w_head.is_read) ? w_head.data : '0;
  assign busy    = (w_count != '0);

endmodule

// File: tb/tb_sram_like_data_responder.sv
// Directed self-checking bench for sram_like_data_responder.
module tb_sram_like_data_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [3:0]  cfg_delay;
  logic        busy;

  int n_checks = 0;
  int n_bad    = 0;

  sram_like_data_responder #(
    .AW          (10),
    .OUTSTANDING (2),
    .DLY_W       (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata),
    .cfg_delay (cfg_delay),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [3:0] dly);
    req       = 1'b1;
    wr        = w;
    addr      = a;
    wstrb     = s;
    wdata     = d;
    cfg_delay = dly;
  endtask

  task automatic idle();
    req   = 1'b0;
    wr    = 1'b0;
    wstrb = '0;
    wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        exp_ok;
    logic [31:0] exp_rd;

    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = '0;
    wstrb = '0; wdata = '0; cfg_delay = '0;
    cyc(); cyc();
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rdata",   rdata,   0);
    chk("rst_busy",    busy,    0);
    reset = 1'b0;
    chk("post_rst_addr_ok_low", addr_ok, 0);
    cyc();
    chk("post_rst_addr_ok_high", addr_ok, 1);

    // Preload mem[4], mem[5], mem[6] back to back
    set_req(1'b1, 32'h10, 4'hF, 32'h11223344, 4'd0); cyc();
    set_req(1'b1, 32'h14, 4'hF, 32'hCAFEF00D, 4'd0);
    chk("pre_wr_resp_ok", data_ok, 1);
    chk("pre_wr_resp_rd", rdata, 0);
    cyc();
    set_req(1'b1, 32'h18, 4'hF, 32'h0BADBEEF, 4'd0); cyc();
    idle(); cyc(); cyc();

    // Test 1: simple read, zero delay
    set_req(1'b0, 32'h10, 4'h0, 32'h0, 4'd0);
    chk("t1_addr_ok", addr_ok, 1);
    cyc(); idle();
    chk("t1_data_ok", data_ok, 1);
    chk("t1_rdata",   rdata,   32'h11223344);
    chk("t1_busy_t1", busy,    1);
    cyc();
    chk("t1_busy_t2", busy,    0);
    chk("t1_no_dok",  data_ok, 0);

    // Test 2: lane write then read of same word
    set_req(1'b1, 32'h10, 4'b0100, 32'h00AB0000, 4'd0);
    chk("t2_wr_addr_ok", addr_ok, 1);
    cyc();
    set_req(1'b0, 32'h10, 4'h0, 32'h0, 4'd0);
    chk("t2_rd_addr_ok", addr_ok, 1);
    chk("t2_wr_dok",     data_ok, 1);
    chk("t2_wr_rdata",   rdata,   0);
    cyc(); idle();
    chk("t2_rd_dok",   data_ok, 1);
    chk("t2_rd_rdata", rdata,   32'h11AB3344);
    cyc();
    chk("t2_quiet", data_ok, 0);

    // wstrb=0 write: responds but leaves memory untouched
    set_req(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 4'd0); cyc();
    set_req(1'b0, 32'h10, 4'h0, 32'h0, 4'd0);
    chk("nop_wr_dok", data_ok, 1);
    cyc(); idle();
    chk("nop_rd_rdata", rdata, 32'h11AB3344);
    cyc();

    // Test 3: three reads, delay 5, two outstanding max
    set_req(1'b0, 32'h10, 4'h0, 32'h0, 4'd5);
    chk("t3_a_addr_ok", addr_ok, 1);
    cyc();
    set_req(1'b0, 32'h14, 4'h0, 32'h0, 4'd5);
    chk("t3_b_addr_ok", addr_ok, 1);
    cyc();
    set_req(1'b0, 32'h18, 4'h0, 32'h0, 4'd5);
    for (int k = 2; k <= 14; k++) begin
      exp_ok = (k == 6) || (k == 7) || (k == 13);
      exp_rd = (k == 6) ? 32'h11AB3344 : (k == 7) ? 32'hCAFEF00D :
               (k == 13) ? 32'h0BADBEEF : 32'h0;
      if (k <= 7) chk($sformatf("t3_addr_ok_%0d", k), addr_ok, (k == 7) ? 1 : 0);
      chk($sformatf("t3_dok_%0d", k), data_ok, exp_ok);
      chk($sformatf("t3_rd_%0d", k),  rdata,   exp_rd);
      cyc();
      if (k == 7) idle();
    end

    // Test 4: slow head blocks a ready younger entry
    set_req(1'b0, 32'h14, 4'h0, 32'h0, 4'd6); cyc();
    set_req(1'b0, 32'h18, 4'h0, 32'h0, 4'd0);
    chk("t4_b_addr_ok", addr_ok, 1);
    cyc(); idle();
    for (int k = 2; k <= 9; k++) begin
      exp_ok = (k == 7) || (k == 8);
      exp_rd = (k == 7) ? 32'hCAFEF00D : (k == 8) ? 32'h0BADBEEF : 32'h0;
      chk($sformatf("t4_dok_%0d", k), data_ok, exp_ok);
      chk($sformatf("t4_rd_%0d", k),  rdata,   exp_rd);
      cyc();
    end

    // Test 5: reset discards outstanding reads
    set_req(1'b0, 32'h10, 4'h0, 32'h0, 4'd4); cyc();
    set_req(1'b0, 32'h14, 4'h0, 32'h0, 4'd4); cyc();
    idle();
    reset = 1'b1;
    chk("t5_rst_addr_ok", addr_ok, 0);
    chk("t5_rst_dok",     data_ok, 0);
    cyc();
    reset = 1'b0;
    chk("t5_after_addr_ok", addr_ok, 0);
    chk("t5_after_busy",    busy,    0);
    cyc();
    chk("t5_back_addr_ok", addr_ok, 1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t5_no_dok_%0d", k), data_ok, 0);
      cyc();
    end

    // Test 6: high address bits ignored, max delay
    set_req(1'b0, 32'hFFFF_F010, 4'h0, 32'h0, 4'd15);
    chk("t6_addr_ok", addr_ok, 1);
    cyc(); idle();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t6_dok_%0d", k), data_ok, (k == 16) ? 1 : 0);
      if (k == 16) chk("t6_rdata", rdata, 32'h11AB3344);
      cyc();
    end
    chk("t6_busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
